count_display_scanner: RTL and testbench

//  Downstream consumer of the slow 4-bit divided-clock counter value. Brings q_in
//  (changes on a derived clock, bits not coherent) into the clk domain through a

---
 rtl/count_display_pkg.sv | 52 +++++
 rtl/count_input_filter.sv | 64 ++++++
 rtl/count_display_scanner.sv | 93 +++++++++
 tb/tb_count_display_scanner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/count_display_pkg.sv
// Shared constants, types and helpers for the count display scanner.
package count_display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  typedef logic [1:0] digit_idx_t;

  // Active-low 7-segment font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] s;
    case (value)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Three-digit BCD increment {hundreds,tens,ones}; 999 rolls over to 000.
  function automatic logic [11:0] bcd_inc(input logic [11:0] value);
    logic [11:0] r;
    logic        carry;
    r     = value;
    carry = 1'b1;
    for (int unsigned d = 0; d < 3; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/count_input_filter.sv
// Synchronizes the asynchronous 4-bit counter value and accepts it only
// after it has been seen unchanged for STABLE_CYCLES consecutive samples.
module count_input_filter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] q_in,
  output logic [3:0] q_stable,
  output logic       q_valid,
  output logic       accept_wrap
);

  localparam int unsigned     CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [3:0]       sync_pipe [SYNC_STAGES];
  logic [3:0]       sync_q;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign sync_q = sync_pipe[SYNC_STAGES-1];
  assign accept = (cnt == CNT_MAX) && (cand != q_stable);

  // Combinational so the wrap counter can update on the same edge as q_stable.
  assign accept_wrap = accept && (q_stable == 4'hF) && (cand == 4'h0);

  // Multi-stage synchronizer, one shift chain per bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= '0;
    end else begin
      sync_pipe[0] <= q_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  // Stability filter: restart on any change, saturate once stable long enough.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand <= '0;
      cnt  <= '0;
    end else if (sync_q != cand) begin
      cand <= sync_q;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt  <= cnt + 1'b1;
    end
  end

  // Accept a newly stable value with a single-cycle valid pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_stable <= '0;
      q_valid  <= 1'b0;
    end else begin
      q_valid <= accept;
      if (accept) q_stable <= cand;
    end
  end

endmodule

// File: rtl/count_display_scanner.sv
// Filters the divided-clock counter value, counts F->0 wraps in BCD and
// scans the result onto a 4-digit common-anode 7-segment display.
module count_display_scanner #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned REFRESH_DIV   = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  q_in,
  input  logic        clear,
  output logic [3:0]  q_stable,
  output logic        q_valid,
  output logic [11:0] wrap_bcd,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  import count_display_pkg::*;

  localparam int unsigned     PRE_W   = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);

  logic             accept_wrap;
  logic [PRE_W-1:0] pre;
  digit_idx_t       idx;
  logic [3:0]       digit;
  logic             blank;

  count_input_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk         (clk),
    .reset_n     (reset_n),
    .q_in        (q_in),
    .q_stable    (q_stable),
    .q_valid     (q_valid),
    .accept_wrap (accept_wrap)
  );

  // BCD wrap counter; clear takes priority over a simultaneous wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_bcd <= '0;
    end else if (clear) begin
      wrap_bcd <= '0;
    end else if (accept_wrap) begin
      wrap_bcd <= bcd_inc(wrap_bcd);
    end
  end

  // Refresh prescaler and digit index advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Digit selection and leading-zero blanking for the current slot.
  always_comb begin
    digit = q_stable;
    case (idx)
      2'd0:    digit = q_stable;
      2'd1:    digit = wrap_bcd[3:0];
      2'd2:    digit = wrap_bcd[7:4];
      default: digit = wrap_bcd[11:8];
    endcase
    blank = ((idx == 2'd3) && (wrap_bcd[11:8] == 4'd0)) ||
            ((idx == 2'd2) && (wrap_bcd[11:4] == 8'd0));
  end

  // Registered display drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
      seg <= blank ? SEG_BLANK : hex_to_seg(digit);
      dp  <= (idx != 2'd1);
    end
  end

endmodule

// File: tb/tb_count_display_scanner.sv
// Directed self-checking bench for count_display_scanner.
module tb_count_display_scanner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  q_in = 4'h0;
  logic        clear = 1'b0;
  logic [3:0]  q_stable;
  logic        q_valid;
  logic [11:0] wrap_bcd;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vectors = 0;
  int miscompares = 0;
  int ecnt;

  always #5 clk = ~clk;

  count_display_scanner #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .REFRESH_DIV   (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .q_in     (q_in),
    .clear    (clear),
    .q_stable (q_stable),
    .q_valid  (q_valid),
    .wrap_bcd (wrap_bcd),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  // Edges since reset release, used to predict the scan slot.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    q_in = v;
    step(n);
  endtask

  task automatic wrap_once();
    hold(4'hF, 8);
    hold(4'h0, 8);
  endtask

  initial begin
    logic [1:0]  eidx;
    logic [3:0]  ean;
    logic [6:0]  eseg;
    logic        edp;

    // 1. reset values and first edge after release
    step(2);
    check("rst_an", {8'h0, an}, 12'hF);
    check("rst_seg", {5'h0, seg}, 12'h7F);
    check("rst_dp", {11'h0, dp}, 12'h1);
    check("rst_wrap", wrap_bcd, 12'h000);
    check("rst_qs", {8'h0, q_stable}, 12'h0);
    check("rst_qv", {11'h0, q_valid}, 12'h0);
    reset_n = 1'b1;
    step(1);
    check("rel_an", {8'h0, an}, 12'hE);
    check("rel_seg", {5'h0, seg}, 12'h40);
    check("rel_dp", {11'h0, dp}, 12'h1);

    // 2. latency: visible after edge N+6
    q_in = 4'h5;
    step(6);
    check("lat_qv_early", {11'h0, q_valid}, 12'h0);
    check("lat_qs_early", {8'h0, q_stable}, 12'h0);
    step(1);
    check("lat_qv", {11'h0, q_valid}, 12'h1);
    check("lat_qs", {8'h0, q_stable}, 12'h5);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("hold_qv", {11'h0, q_valid}, 12'h0);
    end

    // 3. glitch of two samples is rejected
    q_in = 4'h7;
    step(2);
    q_in = 4'h5;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("glitch_qv", {11'h0, q_valid}, 12'h0);
    end
    check("glitch_qs", {8'h0, q_stable}, 12'h5);

    // 4. full count sequence gives one wrap; skipped jump does not
    for (int v = 0; v < 16; v++) hold(4'(v), 10);
    check("seq_qs_f", {8'h0, q_stable}, 12'hF);
    check("seq_wrap0", wrap_bcd, 12'h000);
    hold(4'h0, 10);
    check("seq_qs_0", {8'h0, q_stable}, 12'h0);
    check("seq_wrap1", wrap_bcd, 12'h001);
    hold(4'h3, 10);
    hold(4'h9, 10);
    check("jump_qs", {8'h0, q_stable}, 12'h9);
    check("jump_wrap", wrap_bcd, 12'h001);
    repeat (8) wrap_once();
    check("wrap9", wrap_bcd, 12'h009);
    wrap_once();
    check("wrap10", wrap_bcd, 12'h010);

    // 5. scan with wrap=010, q_stable=0: digit3 blanked, digit2 shows 1
    for (int i = 0; i < 16; i++) begin
      step(1);
      eidx = 2'(((ecnt - 1) >> 2) & 3);
      case (eidx)
        2'd0:    begin ean = 4'b1110; eseg = 7'h40; edp = 1'b1; end
        2'd1:    begin ean = 4'b1101; eseg = 7'h40; edp = 1'b0; end
        2'd2:    begin ean = 4'b1011; eseg = 7'h79; edp = 1'b1; end
        default: begin ean = 4'b1111; eseg = 7'h7F; edp = 1'b1; end
      endcase
      check("scan_an", {8'h0, an}, {8'h0, ean});
      check("scan_seg", {5'h0, seg}, {5'h0, eseg});
      check("scan_dp", {11'h0, dp}, {11'h0, edp});
    end

    // 6. clear on the same edge as an F->0 accept wins
    hold(4'hF, 8);
    q_in = 4'h0;
    step(6);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_qv", {11'h0, q_valid}, 12'h1);
    check("clr_wrap", wrap_bcd, 12'h000);
    step(3);
    check("clr_wrap_late", wrap_bcd, 12'h000);

    // rollover through 100 and 999 to 000
    repeat (100) wrap_once();
    check("wrap100", wrap_bcd, 12'h100);
    repeat (899) wrap_once();
    check("wrap999", wrap_bcd, 12'h999);
    wrap_once();
    check("wrap000", wrap_bcd, 12'h000);
    wrap_once();
    hold(4'hF, 8);
    check("pre_rst_wrap", wrap_bcd, 12'h001);
    check("pre_rst_qs", {8'h0, q_stable}, 12'hF);

    // asynchronous reset mid-scan takes effect before the next edge
    reset_n = 1'b0;
    #2;
    check("arst_an", {8'h0, an}, 12'hF);
    check("arst_seg", {5'h0, seg}, 12'h7F);
    check("arst_dp", {11'h0, dp}, 12'h1);
    check("arst_wrap", wrap_bcd, 12'h000);
    check("arst_qs", {8'h0, q_stable}, 12'h0);
    check("arst_qv", {11'h0, q_valid}, 12'h0);
    step(2);
    q_in = 4'h0;
    reset_n = 1'b1;
    step(1);
    check("rerel_an", {8'h0, an}, 12'hE);
    check("rerel_seg", {5'h0, seg}, 12'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
